// File: rtl/serial_ifft_coral_synth.sv
// Serial single-bin inverse transform: one complex coefficient per channel in,
// FRAME_LENGTH saturated time-domain samples per channel out, one per clock.
module serial_ifft_coral_synth #(
    parameter int W_WIDTH      = 16,
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int FRAME_LENGTH = 10,
    parameter int CHANELS      = 2,
    parameter int SHIFT        = 15
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [CHANELS-1:0][S_WIDTH-1:0]     re,
    input  logic [CHANELS-1:0][S_WIDTH-1:0]     im,
    output logic [$clog2(FRAME_LENGTH)-1:0]     counter,
    input  logic [W_WIDTH-1:0]                  w_re,
    input  logic [W_WIDTH-1:0]                  w_im,
    output logic [CHANELS-1:0][X_WIDTH-1:0]     x,
    output logic                                valid_o,
    output logic                                finish
);

    localparam int CW = $clog2(FRAME_LENGTH);
    localparam int PW = S_WIDTH + W_WIDTH;
    localparam int DW = PW + 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LENGTH - 1);
    localparam logic signed [DW-1:0] X_MAX = {{(DW-X_WIDTH+1){1'b0}}, {(X_WIDTH-1){1'b1}}};
    localparam logic signed [DW-1:0] X_MIN = {{(DW-X_WIDTH+1){1'b1}}, {(X_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_next;
    logic [CW-1:0]                counter_next;
    logic                         hold_full, take, load_active;
    logic [CHANELS-1:0][S_WIDTH-1:0] hold_re, hold_im, act_re, act_im, s2_re, s2_im;
    logic                         s1_valid, s1_last, s2_valid, s2_last;
    logic [CHANELS-1:0][X_WIDTH-1:0] sample;

    assign ready_o  = !hold_full;
    assign take     = valid_i && ready_o;
    assign s1_valid = (state == RUN);
    assign s1_last  = (counter == LAST);

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        load_active  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_next   = RUN;
                    counter_next = '0;
                    load_active  = 1'b1;
                end
            end
            RUN: begin
                if (counter == LAST) begin
                    counter_next = '0;
                    if (hold_full) load_active = 1'b1;
                    else           state_next  = IDLE;
                end else begin
                    counter_next = counter + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // NOTE: coefficient registers are reset too, so an aborted frame leaves no stale data behind.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold_full <= 1'b0;
            hold_re   <= '0;
            hold_im   <= '0;
            act_re    <= '0;
            act_im    <= '0;
        end else begin
            if (take) begin
                hold_re   <= re;
                hold_im   <= im;
                hold_full <= 1'b1;
            end else if (load_active) begin
                hold_full <= 1'b0;
            end
            if (load_active) begin
                act_re <= hold_re;
                act_im <= hold_im;
            end
        end
    end

    // Coefficients travel with the ROM read so a reload cannot touch in-flight samples.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            s2_re    <= act_re;
            s2_im    <= act_im;
        end
    end

    for (genvar c = 0; c < CHANELS; c++) begin : g_ch
        logic signed [PW-1:0] prod_re, prod_im;
        logic signed [DW-1:0] diff, shifted;

        assign prod_re = PW'($signed(s2_re[c])) * PW'($signed(w_re));
        assign prod_im = PW'($signed(s2_im[c])) * PW'($signed(w_im));
        assign diff    = DW'(prod_re) - DW'(prod_im);
        assign shifted = diff >>> SHIFT;
        assign sample[c] = (shifted > X_MAX) ? {1'b0, {(X_WIDTH-1){1'b1}}} :
                           (shifted < X_MIN) ? {1'b1, {(X_WIDTH-1){1'b0}}} :
                                               shifted[X_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            x       <= '0;
            valid_o <= 1'b0;
            finish  <= 1'b0;
        end else begin
            valid_o <= s2_valid;
            finish  <= s2_valid && s2_last;
            if (s2_valid) x <= sample;
        end
    end

endmodule

// File: tb/tb_serial_ifft_coral_synth.sv
// Bench for serial_ifft_coral_synth: directed scenarios plus random frames,
// compared against an arithmetic model of the synthesis equation.
module tb_serial_ifft_coral_synth;

    localparam int FL = 4;
    localparam int SH = 14;
    localparam int CH = 2;
    localparam int XW = 16;
    localparam int SW = 32;
    localparam int WW = 16;

    typedef logic [CH-1:0][SW-1:0] coef_t;
    typedef struct packed {
        logic [CH-1:0][XW-1:0] x;
        logic                  last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  arst, valid_i, ready_o, valid_o, finish;
    coef_t                 re, im;
    logic [1:0]            counter;
    logic [WW-1:0]         w_re, w_im;
    logic [CH-1:0][XW-1:0] x;

    int   rom_re [FL];
    int   rom_im [FL];
    exp_t exp_q[$];
    int   n_asserts = 0, n_fail = 0;
    int   n_valid = 0, n_fin = 0, run_len = 0, max_run = 0;

    serial_ifft_coral_synth #(
        .W_WIDTH(WW), .X_WIDTH(XW), .S_WIDTH(SW),
        .FRAME_LENGTH(FL), .CHANELS(CH), .SHIFT(SH)
    ) dut (
        .clk(clk), .arst(arst), .valid_i(valid_i), .ready_o(ready_o),
        .re(re), .im(im), .counter(counter), .w_re(w_re), .w_im(w_im),
        .x(x), .valid_o(valid_o), .finish(finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_re <= WW'(rom_re[counter]);
        w_im <= WW'(rom_im[counter]);
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [XW-1:0] synth(longint r, longint i, longint wr, longint wi);
        longint v;
        longint hi = (longint'(1) << (XW - 1)) - 1;
        longint lo = -(longint'(1) << (XW - 1));
        v = (r * wr - i * wi) >>> SH;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return XW'(v);
    endfunction

    task automatic push_frame(input coef_t r, input coef_t i);
        exp_t e;
        for (int n = 0; n < FL; n++) begin
            for (int c = 0; c < CH; c++)
                e.x[c] = synth($signed(r[c]), $signed(i[c]), rom_re[n], rom_im[n]);
            e.last = (n == FL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic send(input coef_t r, input coef_t i);
        logic hs;
        int   budget = 0;
        re      = r;
        im      = i;
        valid_i = 1'b1;
        do begin
            hs = ready_o;
            step();
            budget++;
        end while (!hs && budget < 50);
        valid_i = 1'b0;
        check("send_accepted", hs, 1);
        if (hs) push_frame(r, i);
    endtask

    task automatic check_latency();
        step();
        check("addr_after_load", counter, 0);
        check("valid_lat1", valid_o, 0);
        step();
        check("valid_lat2", valid_o, 0);
        step();
        check("valid_lat3", valid_o, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!arst) begin
            if (valid_o) begin
                n_valid++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (finish) n_fin++;
                check("sample_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < CH; c++)
                        check($sformatf("x_ch%0d", c), $signed(x[c]), $signed(e.x[c]));
                    check("finish_pos", finish, e.last);
                end
            end else begin
                run_len = 0;
                check("finish_idle", finish, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        coef_t ra, ia, rb, ib, rc;
        int    bv, bf, seen, budget;
        logic signed [SW-1:0] t;

        rom_re = '{16384, 0, -16384, 0};
        rom_im = '{0, 16384, 0, -16384};
        arst = 1'b1; valid_i = 1'b0; re = '0; im = '0;
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_finish", finish, 0);
        check("rst_x", x, 0);
        check("rst_counter", counter, 0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        step();

        ra = {32'sd0, 32'sd100}; ia = {32'sd50, 32'sd0};
        rb = {-32'sd7, 32'sd7};  ib = '0;
        rc = {32'sd3, -32'sd3};

        // single frame with latency
        bv = n_valid; bf = n_fin;
        send(ra, ia);
        check("ready_drop", ready_o, 0);
        check_latency();
        drain(10);
        check("single_count", n_valid - bv, FL);
        check("single_finish", n_fin - bf, 1);

        // back-to-back, gapless
        bv = n_valid; bf = n_fin; max_run = 0;
        send(ra, ia);
        send(rb, ib);
        drain(16);
        check("b2b_count", n_valid - bv, 2 * FL);
        check("b2b_run", max_run, 2 * FL);
        check("b2b_finish", n_fin - bf, 2);

        // holding full blocks a third transfer
        bv = n_valid; bf = n_fin; max_run = 0;
        send(ra, ia);
        send(rb, ib);
        re = rc; im = '0; valid_i = 1'b1;
        check("blocked_ready0", ready_o, 0);
        step();
        check("blocked_ready1", ready_o, 0);
        send(rc, '0);
        drain(20);
        check("hold_count", n_valid - bv, 3 * FL);
        check("hold_run", max_run, 3 * FL);
        check("hold_finish", n_fin - bf, 3);

        // transfer on the last cycle with holding empty: one idle gap
        bv = n_valid; bf = n_fin; max_run = 0;
        send(rb, ib);
        budget = 0;
        while (counter != 2'(FL - 1) && budget < 20) begin step(); budget++; end
        check("last_cycle_addr", counter, FL - 1);
        send(ra, ia);
        drain(16);
        check("gap_count", n_valid - bv, 2 * FL);
        check("gap_run", max_run, FL);
        check("gap_finish", n_fin - bf, 2);

        // saturation
        send({-32'sd1048576, 32'sd1048576}, '0);
        drain(10);

        // reset mid-frame
        send(ra, ia);
        seen = 0; budget = 0;
        while (seen < 2 && budget < 30) begin
            step();
            if (valid_o) seen++;
            budget++;
        end
        check("reset_window", seen, 2);
        arst = 1'b1;
        exp_q.delete();
        bv = n_valid; bf = n_fin;
        #1;
        check("mid_rst_x", x, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_finish", finish, 0);
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_counter", counter, 0);
        step();
        arst = 1'b0;
        drain(10);
        check("post_rst_valid", n_valid - bv, 0);
        check("post_rst_finish", n_fin - bf, 0);
        send(rb, ib);
        check_latency();
        drain(10);
        check("post_rst_drained", exp_q.size(), 0);

        // random coefficients and twiddles
        for (int n = 0; n < FL; n++) begin
            rom_re[n] = int'($urandom_range(0, 65535)) - 32768;
            rom_im[n] = int'($urandom_range(0, 65535)) - 32768;
        end
        bv = n_valid; bf = n_fin;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CH; c++) begin
                t = $urandom; ra[c] = t >>> $urandom_range(0, 24);
                t = $urandom; ia[c] = t >>> $urandom_range(0, 24);
            end
            send(ra, ia);
            drain($urandom_range(0, 5));
        end
        drain(30);
        check("rand_count", n_valid - bv, 10 * FL);
        check("rand_finish", n_fin - bf, 10);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
